// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the two-requester RAM port arbiter: port ids, priority
// state, in-flight read entries and the combinational arbitration rule.
package ram_port_arbiter_pkg;

    localparam logic PORT1_ID = 1'b0;
    localparam logic PORT2_ID = 1'b1;

    typedef enum logic {
        PRIO_PORT1 = 1'b0,
        PRIO_PORT2 = 1'b1
    } prio_e;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_P1   = 2'd1,
        GRANT_P2   = 2'd2
    } grant_e;

    typedef struct packed {
        logic valid;
        logic id;
    } inflight_t;

    function automatic grant_e arbitrate(input logic v1, input logic v2, input prio_e prio);
        grant_e g;
        g = GRANT_NONE;
        if (v1 && (!v2 || prio == PRIO_PORT1)) begin
            g = GRANT_P1;
        end else if (v2) begin
            g = GRANT_P2;
        end else begin
            g = GRANT_NONE;
        end
        return g;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester handshakes for both ports plus the shared RAM port signals.
// The arbiter sits on the slave modport; requesters and the RAM on master.
interface ram_port_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    logic                  valid1;
    logic                  ready1;
    logic                  write1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] idata1;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata1;

    logic                  valid2;
    logic                  ready2;
    logic                  write2;
    logic [ADDR_WIDTH-1:0] addr2;
    logic [DATA_WIDTH-1:0] idata2;
    logic                  rvalid2;
    logic [DATA_WIDTH-1:0] rdata2;

    logic                  ram_enable;
    logic                  ram_write;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_idata;
    logic [DATA_WIDTH-1:0] ram_odata;

    modport slave (
        input  valid1, write1, addr1, idata1,
        output ready1, rvalid1, rdata1,
        input  valid2, write2, addr2, idata2,
        output ready2, rvalid2, rdata2,
        output ram_enable, ram_write, ram_addr, ram_idata,
        input  ram_odata
    );

    modport master (
        output valid1, write1, addr1, idata1,
        input  ready1, rvalid1, rdata1,
        output valid2, write2, addr2, idata2,
        input  ready2, rvalid2, rdata2,
        input  ram_enable, ram_write, ram_addr, ram_idata,
        output ram_odata
    );

endinterface

// File: rtl/ram_arbiter_pipe.sv
// LATENCY-deep shift register of {valid, id} entries that follows each
// accepted request until its RAM read data appears.
module ram_arbiter_pipe
    import ram_port_arbiter_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic      clock,
    input  logic      reset,
    input  inflight_t head,
    output inflight_t tail
);

    inflight_t stage_r [LATENCY];

    // Shift entries one stage per clock; reset drops everything in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= head;
            for (int i = 1; i < LATENCY; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign tail = stage_r[LATENCY-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one block-RAM port between two requesters and
// steering each read result back to the port that issued it.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 1
) (
    input  logic               clock,
    input  logic               reset,
    ram_port_arbiter_if.slave  bus
);

    if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
        $fatal(1, "ram_port_arbiter: LATENCY must be 1 or 2");
    end

    prio_e                 prio_r;
    prio_e                 prio_next_s;
    grant_e                grant_s;
    inflight_t             head_s;
    inflight_t             tail_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [DATA_WIDTH-1:0] idata_s;

    // Grant selection; nothing is granted while reset is held.
    always_comb begin
        grant_s = GRANT_NONE;
        if (reset) begin
            grant_s = GRANT_NONE;
        end else begin
            grant_s = arbitrate(bus.valid1, bus.valid2, prio_r);
        end
    end

    // The port just served loses preference; idle cycles keep it.
    always_comb begin
        prio_next_s = prio_r;
        case (grant_s)
            GRANT_P1: prio_next_s = PRIO_PORT2;
            GRANT_P2: prio_next_s = PRIO_PORT1;
            default:  prio_next_s = prio_r;
        endcase
    end

    // Priority state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prio_r <= PRIO_PORT1;
        end else begin
            prio_r <= prio_next_s;
        end
    end

    // Mux the granted request onto the RAM port and tag reads for return.
    always_comb begin
        bus.ready1     = 1'b0;
        bus.ready2     = 1'b0;
        bus.ram_enable = 1'b0;
        bus.ram_write  = 1'b0;
        addr_s         = '0;
        idata_s        = '0;
        head_s         = '0;
        case (grant_s)
            GRANT_P1: begin
                bus.ready1     = 1'b1;
                bus.ram_enable = 1'b1;
                bus.ram_write  = bus.write1;
                addr_s         = bus.addr1;
                idata_s        = bus.idata1;
                head_s.valid   = ~bus.write1;
                head_s.id      = PORT1_ID;
            end
            GRANT_P2: begin
                bus.ready2     = 1'b1;
                bus.ram_enable = 1'b1;
                bus.ram_write  = bus.write2;
                addr_s         = bus.addr2;
                idata_s        = bus.idata2;
                head_s.valid   = ~bus.write2;
                head_s.id      = PORT2_ID;
            end
            default: begin
                head_s = '0;
            end
        endcase
    end

    assign bus.ram_addr  = addr_s;
    assign bus.ram_idata = idata_s;

    ram_arbiter_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clock (clock),
        .reset (reset),
        .head  (head_s),
        .tail  (tail_s)
    );

    // Read data is shared; only the rvalid of the issuing port rises.
    assign bus.rvalid1 = tail_s.valid && (tail_s.id == PORT1_ID);
    assign bus.rvalid2 = tail_s.valid && (tail_s.id == PORT2_ID);
    assign bus.rdata1  = bus.ram_odata;
    assign bus.rdata2  = bus.ram_odata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench: two arbiters (RAM latency 1 and 2) see identical
// stimulus; a reference model predicts grants and read results.
module tb_ram_port_arbiter;

    typedef struct {
        bit         port;
        logic [7:0] data;
        int         due;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       v1, w1, v2, w2;
    logic [9:0] a1, a2;
    logic [7:0] d1, d2;

    logic [7:0] mem_a [1024];
    logic [7:0] mem_b [1024];
    logic [7:0] ref_mem [1024];
    logic [7:0] q_a, q_b1, q_b2;

    exp_t q1[$];
    exp_t q2[$];
    bit   prio_m;
    bit   g1, g2;
    int   cyc;
    int   n_vec;
    int   n_err;

    always #5 clock = ~clock;

    ram_port_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) bus_a ();
    ram_port_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) bus_b ();

    ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .LATENCY(1)) u_lat1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .LATENCY(2)) u_lat2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    assign bus_a.valid1 = v1;  assign bus_b.valid1 = v1;
    assign bus_a.write1 = w1;  assign bus_b.write1 = w1;
    assign bus_a.addr1  = a1;  assign bus_b.addr1  = a1;
    assign bus_a.idata1 = d1;  assign bus_b.idata1 = d1;
    assign bus_a.valid2 = v2;  assign bus_b.valid2 = v2;
    assign bus_a.write2 = w2;  assign bus_b.write2 = w2;
    assign bus_a.addr2  = a2;  assign bus_b.addr2  = a2;
    assign bus_a.idata2 = d2;  assign bus_b.idata2 = d2;

    // Read-first single-port RAM, output unregistered (one cycle latency).
    always @(posedge clock) begin
        if (bus_a.ram_enable) begin
            if (bus_a.ram_write) mem_a[bus_a.ram_addr] <= bus_a.ram_idata;
            q_a <= mem_a[bus_a.ram_addr];
        end
    end
    assign bus_a.ram_odata = q_a;

    // Same RAM with an output register (two cycle latency).
    always @(posedge clock) begin
        if (bus_b.ram_enable) begin
            if (bus_b.ram_write) mem_b[bus_b.ram_addr] <= bus_b.ram_idata;
            q_b1 <= mem_b[bus_b.ram_addr];
        end
        q_b2 <= q_b1;
    end
    assign bus_b.ram_odata = q_b2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic chk_drive(input string t, input logic rdy1, input logic rdy2, input logic en,
                             input logic wr, input logic [9:0] ad, input logic [7:0] dt);
        logic       e_wr;
        logic [9:0] e_ad;
        logic [7:0] e_dt;
        e_wr = g1 ? w1 : (g2 ? w2 : 1'b0);
        e_ad = g1 ? a1 : (g2 ? a2 : 10'd0);
        e_dt = g1 ? d1 : (g2 ? d2 : 8'd0);
        chk({t, " ready1"}, rdy1, g1);
        chk({t, " ready2"}, rdy2, g2);
        chk({t, " ram_enable"}, en, g1 | g2);
        chk({t, " ram_write"}, wr, e_wr);
        chk({t, " ram_addr"}, ad, e_ad);
        chk({t, " ram_idata"}, dt, e_dt);
    endtask

    task automatic mon(input int lat, input logic rv1, input logic rv2,
                       input logic [7:0] rd1, input logic [7:0] rd2);
        exp_t  e;
        bit    have;
        bit    due_now;
        string t;
        t = (lat == 1) ? "L1" : "L2";
        e = '{port: 1'b0, data: 8'd0, due: 0};
        have = (lat == 1) ? (q1.size() > 0) : (q2.size() > 0);
        if (have) e = (lat == 1) ? q1[0] : q2[0];
        due_now = have && (e.due <= cyc);
        chk({t, " rvalid1"}, rv1, due_now && !e.port);
        chk({t, " rvalid2"}, rv2, due_now && e.port);
        if (due_now) begin
            chk({t, " rdata"}, e.port ? rd2 : rd1, e.data);
            if (lat == 1) void'(q1.pop_front());
            else          void'(q2.pop_front());
        end
    endtask

    // Cycle counter.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clock);
            cyc = cyc + 1;
        end
    end

    // Reference model: predict grants, RAM drive and read results.
    initial begin
        exp_t       e;
        bit         wr;
        logic [9:0] ad;
        logic [7:0] dt;
        prio_m = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                chk("rst ready1", bus_a.ready1 | bus_b.ready1, 0);
                chk("rst ready2", bus_a.ready2 | bus_b.ready2, 0);
                chk("rst ram_enable", bus_a.ram_enable | bus_b.ram_enable, 0);
                chk("rst rvalid", bus_a.rvalid1 | bus_a.rvalid2 | bus_b.rvalid1 | bus_b.rvalid2, 0);
                prio_m = 1'b0;
                q1.delete();
                q2.delete();
            end else begin
                g1 = v1 && (!v2 || !prio_m);
                g2 = v2 && (!v1 || prio_m);
                chk_drive("L1", bus_a.ready1, bus_a.ready2, bus_a.ram_enable, bus_a.ram_write,
                          bus_a.ram_addr, bus_a.ram_idata);
                chk_drive("L2", bus_b.ready1, bus_b.ready2, bus_b.ram_enable, bus_b.ram_write,
                          bus_b.ram_addr, bus_b.ram_idata);
                if (g1 || g2) begin
                    wr = g1 ? w1 : w2;
                    ad = g1 ? a1 : a2;
                    dt = g1 ? d1 : d2;
                    if (wr) begin
                        ref_mem[ad] = dt;
                    end else begin
                        e = '{port: g2, data: ref_mem[ad], due: cyc + 1};
                        q1.push_back(e);
                        e.due = cyc + 2;
                        q2.push_back(e);
                    end
                    prio_m = g1;
                end
            end
        end
    end

    // Response monitor for both latencies.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                mon(1, bus_a.rvalid1, bus_a.rvalid2, bus_a.rdata1, bus_a.rdata2);
                mon(2, bus_b.rvalid1, bus_b.rvalid2, bus_b.rdata1, bus_b.rdata2);
            end
        end
    end

    task automatic drive(input int rv1, input int rw1, input int ra1, input int rd1,
                         input int rv2, input int rw2, input int ra2, input int rd2);
        @(posedge clock);
        #1;
        v1 = rv1[0]; w1 = rw1[0]; a1 = ra1[9:0]; d1 = rd1[7:0];
        v2 = rv2[0]; w2 = rw2[0]; a2 = ra2[9:0]; d2 = rd2[7:0];
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        v1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0;
        v2 = 1'b0; w2 = 1'b0; a2 = '0; d2 = '0;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 8'd0; mem_b[i] = 8'd0; ref_mem[i] = 8'd0;
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Port 1 write then read back.
        drive(1, 1, 5, 'hA5, 0, 0, 0, 0);
        drive(1, 0, 5, 0, 0, 0, 0, 0);
        idle(3);

        // Reset, then eight cycles of contended reads.
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        for (int i = 0; i < 8; i++) drive(1, 0, i, 0, 1, 0, i + 8, 0);
        idle(3);

        // Port 2 write followed by port 1 read of the same address.
        drive(0, 0, 0, 0, 1, 1, 3, 'h3C);
        drive(1, 0, 3, 0, 0, 0, 0, 0);
        idle(3);

        // Port 2 alone, then contention.
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0, 3, 0);
        for (int i = 0; i < 2; i++) drive(1, 0, 5, 0, 1, 0, 3, 0);
        idle(3);

        // Reset while a read is in flight.
        drive(1, 0, 5, 0, 0, 0, 0, 0);
        @(posedge clock); #1 reset = 1'b1; v1 = 1'b1; v2 = 1'b1; w1 = 1'b0; w2 = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        drive(1, 0, 3, 0, 1, 0, 5, 0);
        idle(3);

        // Random traffic over a small address range to force collisions.
        repeat (400) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255));
        end
        idle(6);

        chk("L1 drained", q1.size(), 0);
        chk("L2 drained", q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
